// File: rtl/rat_spec_ckpt.sv
`default_nettype none
// ============================================================================
//  Module   : rat_spec_ckpt
//  Purpose  : Speculative register alias table for an RW-wide rename stage,
//             with its own architectural copy. Combinational source and
//             old-destination lookups include a same-group bypass in which
//             the youngest older writer wins. Commits update the arch copy.
//             Flush recovery copies arch onto spec (RESTORE) and then
//             replays the ROB walk (WALK).
//  Option   : RAT_SNAPSHOT_EN adds NSNAP snapshot slots (take/restore).
//  Revision : 1.0  initial release
// ============================================================================
module rat_spec_ckpt #(
  parameter int RW     = 2,
  parameter int NLREG  = 32,
  parameter int NPREG  = 64,
  parameter int NSNAP  = 4,
  localparam int LREG_W = $clog2(NLREG),
  localparam int PREG_W = $clog2(NPREG),
  localparam int SNAP_W = $clog2(NSNAP)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [RW*LREG_W-1:0] rd_lrs1,
  input  logic [RW*LREG_W-1:0] rd_lrs2,
  input  logic [RW*LREG_W-1:0] rd_lrd,
  input  logic [RW*3-1:0]      rd_en,
  output logic [RW*PREG_W-1:0] rd_prs1,
  output logic [RW*PREG_W-1:0] rd_prs2,
  output logic [RW*PREG_W-1:0] rd_old_prd,
  input  logic [RW-1:0]        ren_valid,
  input  logic [RW*LREG_W-1:0] ren_lrd,
  input  logic [RW*PREG_W-1:0] ren_prd,
  input  logic [RW-1:0]        cmt_valid,
  input  logic [RW*LREG_W-1:0] cmt_lrd,
  input  logic [RW*PREG_W-1:0] cmt_prd,
  input  logic                 flush_valid,
  input  logic [RW-1:0]        walk_valid,
  input  logic [RW*LREG_W-1:0] walk_lrd,
  input  logic [RW*PREG_W-1:0] walk_prd,
  input  logic                 walk_done,
  output logic                 rat_busy,
  input  logic                 snap_take,
  input  logic [SNAP_W-1:0]    snap_id,
  input  logic                 snap_restore,
  input  logic [SNAP_W-1:0]    rst_id
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESTORE = 2'd1;
  localparam logic [1:0] S_WALK    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              ren_en, restore_en, walk_en;

  logic [PREG_W-1:0] spec_q [NLREG];
  logic [PREG_W-1:0] spec_d [NLREG];
  logic [PREG_W-1:0] arch_q [NLREG];
  logic [PREG_W-1:0] arch_d [NLREG];

  // Table value for lr as seen by lane 'lane': older same-group renames
  // override the table, the highest older lane last; x0 and disabled read 0.
  function automatic logic [PREG_W-1:0] map_lookup(
    input logic [LREG_W-1:0] lr,
    input logic              en,
    input int                lane
  );
    logic [PREG_W-1:0] v;
    v = spec_q[lr];
    for (int j = 0; j < RW; j++) begin
      if (j < lane && ren_valid[j] && ren_lrd[j*LREG_W +: LREG_W] == lr)
        v = ren_prd[j*PREG_W +: PREG_W];
    end
    if (!en || lr == '0)
      v = '0;
    return v;
  endfunction

  for (genvar k = 0; k < RW; k++) begin : g_lane
    assign rd_prs1[k*PREG_W +: PREG_W]    = map_lookup(rd_lrs1[k*LREG_W +: LREG_W], rd_en[3*k],   k);
    assign rd_prs2[k*PREG_W +: PREG_W]    = map_lookup(rd_lrs2[k*LREG_W +: LREG_W], rd_en[3*k+1], k);
    assign rd_old_prd[k*PREG_W +: PREG_W] = map_lookup(rd_lrd[k*LREG_W +: LREG_W],  rd_en[3*k+2], k);
  end

  assign rat_busy = busy_q;

  // FSM state register; busy is registered alongside the state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // FSM next state: any flush (re)enters RESTORE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (flush_valid) state_d = S_RESTORE;
      S_RESTORE: state_d = flush_valid ? S_RESTORE : S_WALK;
      S_WALK: begin
        if (flush_valid)    state_d = S_RESTORE;
        else if (walk_done) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FSM outputs: which source is allowed to write the speculative table
  always_comb begin
    ren_en     = 1'b0;
    restore_en = 1'b0;
    walk_en    = 1'b0;
    case (state_q)
      S_IDLE:    ren_en     = !flush_valid;
      S_RESTORE: restore_en = 1'b1;
      S_WALK:    walk_en    = !flush_valid;
      default:   ren_en     = 1'b0;
    endcase
  end

  // Arch copy next value: commits in every state, highest lane last
  always_comb begin
    for (int i = 0; i < NLREG; i++)
      arch_d[i] = arch_q[i];
    for (int j = 0; j < RW; j++) begin
      if (cmt_valid[j] && cmt_lrd[j*LREG_W +: LREG_W] != '0)
        arch_d[cmt_lrd[j*LREG_W +: LREG_W]] = cmt_prd[j*PREG_W +: PREG_W];
    end
  end

`ifdef RAT_SNAPSHOT_EN
  logic [PREG_W-1:0] snap_q [NSNAP][NLREG];
  logic [PREG_W-1:0] snap_d [NSNAP][NLREG];
`else
  logic snap_unused;
  assign snap_unused = ^{snap_take, snap_id, snap_restore, rst_id};
`endif

  // Spec table next value: restore from arch (with same-cycle commits),
  // renames in IDLE, walk replay in WALK; highest lane last
  always_comb begin
    for (int i = 0; i < NLREG; i++)
      spec_d[i] = spec_q[i];
    if (restore_en) begin
      for (int i = 0; i < NLREG; i++)
        spec_d[i] = arch_d[i];
    end else if (ren_en) begin
      for (int j = 0; j < RW; j++) begin
        if (ren_valid[j] && ren_lrd[j*LREG_W +: LREG_W] != '0)
          spec_d[ren_lrd[j*LREG_W +: LREG_W]] = ren_prd[j*PREG_W +: PREG_W];
      end
`ifdef RAT_SNAPSHOT_EN
      // a snapshot restore overrides renames of the same cycle
      if (snap_restore) begin
        for (int i = 0; i < NLREG; i++)
          spec_d[i] = snap_q[rst_id][i];
      end
`endif
    end else if (walk_en) begin
      for (int j = 0; j < RW; j++) begin
        if (walk_valid[j] && walk_lrd[j*LREG_W +: LREG_W] != '0)
          spec_d[walk_lrd[j*LREG_W +: LREG_W]] = walk_prd[j*PREG_W +: PREG_W];
      end
    end
  end

`ifdef RAT_SNAPSHOT_EN
  // Snapshot capture of the post-rename table
  always_comb begin
    for (int s = 0; s < NSNAP; s++)
      for (int i = 0; i < NLREG; i++)
        snap_d[s][i] = snap_q[s][i];
    if (snap_take) begin
      for (int i = 0; i < NLREG; i++)
        snap_d[snap_id][i] = spec_d[i];
    end
  end

  // Snapshot storage, identity mapping at reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSNAP; s++)
        for (int i = 0; i < NLREG; i++)
          snap_q[s][i] <= PREG_W'(i);
    end else begin
      for (int s = 0; s < NSNAP; s++)
        for (int i = 0; i < NLREG; i++)
          snap_q[s][i] <= snap_d[s][i];
    end
  end
`endif

  // Spec and arch tables, identity mapping at reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NLREG; i++) begin
        spec_q[i] <= PREG_W'(i);
        arch_q[i] <= PREG_W'(i);
      end
    end else begin
      for (int i = 0; i < NLREG; i++) begin
        spec_q[i] <= spec_d[i];
        arch_q[i] <= arch_d[i];
      end
    end
  end

  // Renaming while the table is recovering is a protocol violation
  a_no_ren_while_busy: assert property (
    @(posedge clock) disable iff (!reset_n) !(busy_q && (|ren_valid))
  );

endmodule
`default_nettype wire
